// File: rtl/fsk_pkg.sv
// fsk_pkg: shared FSK constants, state encoding
// and width helper for the fsk_mod/fsk_dem pair.
package fsk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } fsk_state_t;

  localparam int SYM_LEN_DEF = 16;
  localparam int HALF1_DEF   = 2;
  localparam int HALF0_DEF   = 8;
  // toggles per symbol window that separate '1' from '0'
  localparam int RX_THRESH   = 6;

  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fsk_tone_gen.sv
// fsk_tone_gen: square-tone generator, fast tone
// for '1' and slow tone for '0', phase-continuous.
module fsk_tone_gen
  import fsk_pkg::*;
#(
  parameter int HALF1 = HALF1_DEF,
  parameter int HALF0 = HALF0_DEF
) (
  input  logic sysclk,
  input  logic reset,
  input  logic en,
  input  logic bit_val,
  input  logic restart,
  input  logic clear,
  output logic sig_rf
);

  localparam int HMAX = (HALF0 > HALF1) ? HALF0 : HALF1;
  localparam int TW   = cw(HMAX);
  localparam logic [TW-1:0] T1 = TW'(HALF1 - 1);
  localparam logic [TW-1:0] T0 = TW'(HALF0 - 1);

  logic [TW-1:0] tone_cnt;
  logic [TW-1:0] term;
  logic          hit;

  assign term = bit_val ? T1 : T0;
  assign hit  = (tone_cnt == term);

  // a toggle due on a bit boundary still happens
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      tone_cnt <= '0;
      sig_rf   <= 1'b0;
    end else if (clear) begin
      tone_cnt <= '0;
      sig_rf   <= 1'b0;
    end else if (en) begin
      if (hit) begin
        tone_cnt <= '0;
        sig_rf   <= ~sig_rf;
      end else if (restart) begin
        tone_cnt <= '0;
      end else begin
        tone_cnt <= tone_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fsk_mod.sv
// fsk_mod: parallel-in FSK modulator, MSB first,
// SYM_LEN cycles per bit, framed by sig_enable.
module fsk_mod
  import fsk_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int SYM_LEN = SYM_LEN_DEF,
  parameter int HALF1   = HALF1_DEF,
  parameter int HALF0   = HALF0_DEF
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              sig_rf,
  output logic              sig_enable,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int SW = cw(SYM_LEN);
  localparam int BW = cw(DATA_W);
  localparam logic [SW-1:0] SYM_LAST = SW'(SYM_LEN - 1);
  localparam logic [BW-1:0] BIT_TOP  = BW'(DATA_W - 1);

  fsk_state_t        state_q;
  fsk_state_t        state_d;
  logic [DATA_W-1:0] shreg;
  logic [SW-1:0]     sym_cnt;
  logic [BW-1:0]     bit_idx;
  logic              xfer;
  logic              sending;
  logic              sym_end;
  logic              last_bit;

  assign xfer     = tx_valid && tx_ready;
  assign sending  = (state_q == ST_SEND);
  assign sym_end  = sending && (sym_cnt == SYM_LAST);
  assign last_bit = sym_end && (bit_idx == '0);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (xfer) state_d = ST_SEND;
      ST_SEND: if (last_bit) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // outputs are registered copies of the next state
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      tx_ready   <= 1'b1;
      sig_enable <= 1'b0;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_ready   <= (state_d == ST_IDLE);
      sig_enable <= (state_d == ST_SEND);
      tx_busy    <= (state_d != ST_IDLE);
      tx_done    <= (state_d == ST_DONE);
    end
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      shreg   <= '0;
      sym_cnt <= '0;
      bit_idx <= '0;
    end else if (xfer) begin
      shreg   <= tx_data;
      sym_cnt <= '0;
      bit_idx <= BIT_TOP;
    end else if (sending) begin
      if (sym_end) begin
        sym_cnt <= '0;
        shreg   <= {shreg[DATA_W-2:0], 1'b0};
        if (bit_idx != '0) bit_idx <= bit_idx - 1'b1;
      end else begin
        sym_cnt <= sym_cnt + 1'b1;
      end
    end
  end

  fsk_tone_gen #(
    .HALF1 (HALF1),
    .HALF0 (HALF0)
  ) u_tone (
    .sysclk  (sysclk),
    .reset   (reset),
    .en      (sending),
    .bit_val (shreg[DATA_W-1]),
    .restart (sym_end),
    .clear   (xfer),
    .sig_rf  (sig_rf)
  );

endmodule

// File: tb/tb_fsk_mod.sv
// tb_fsk_mod: randomized self-checking bench for
// fsk_mod against a per-bit tone reference model.
module tb_fsk_mod;

  localparam int NT = 300;
  localparam int RX_TH = 6;

  logic       sysclk;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       sig_rf;
  logic       sig_enable;
  logic       tx_busy;
  logic       tx_done;

  int n_cmp = 0;
  int n_bad = 0;

  logic rf_t [0:NT-1];
  logic en_t [0:NT-1];
  logic dn_t [0:NT-1];
  logic rd_t [0:NT-1];
  logic bz_t [0:NT-1];

  fsk_mod dut (
    .sysclk     (sysclk),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .sig_rf     (sig_rf),
    .sig_enable (sig_enable),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  // level of sig_rf after edge n of a frame (edge 0 = handshake)
  function automatic logic exp_rf(input logic [7:0] w,
                                  input int n);
    logic lv;
    int bi, k, h, lim;
    lv  = 1'b0;
    lim = (n > 128) ? 128 : n;
    for (int m = 1; m <= lim; m++) begin
      bi = (m - 1) / 16;
      k  = (m - 1) % 16 + 1;
      h  = w[7 - bi] ? 2 : 8;
      if (k % h == 0) lv = ~lv;
    end
    return lv;
  endfunction

  // toggle-count receiver over the captured trace
  function automatic logic [7:0] demod();
    logic [7:0] r;
    int c;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      c = 0;
      for (int n = 16 * i + 1; n <= 16 * i + 16; n++)
        if (en_t[n-1] && rf_t[n] != rf_t[n-1]) c++;
      r[7 - i] = (c >= RX_TH);
    end
    return r;
  endfunction

  function automatic int win_tog(input int i);
    int c;
    c = 0;
    for (int n = 16 * i + 1; n <= 16 * i + 16; n++)
      if (rf_t[n] != rf_t[n-1]) c++;
    return c;
  endfunction

  function automatic int rf_errs(input logic [7:0] w);
    int e;
    e = 0;
    for (int n = 0; n <= 128; n++)
      if (rf_t[n] !== exp_rf(w, n)) e++;
    return e;
  endfunction

  task automatic rec(input int n);
    rf_t[n] = sig_rf;
    en_t[n] = sig_enable;
    dn_t[n] = tx_done;
    rd_t[n] = tx_ready;
    bz_t[n] = tx_busy;
  endtask

  task automatic capture(input logic [7:0] w,
                         input bit hold,
                         input int ncyc);
    int b;
    b = 0;
    while (tx_ready !== 1'b1 && b < 400) begin
      @(posedge sysclk); #1;
      b++;
    end
    n_cmp++;
    if (tx_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_timeout got=%b want=1", tx_ready);
    end
    tx_data  = w;
    tx_valid = 1'b1;
    @(posedge sysclk); #1;
    if (!hold) tx_valid = 1'b0;
    tx_data = 8'($urandom);
    rec(0);
    for (int n = 1; n <= ncyc; n++) begin
      if (hold) tx_data = 8'($urandom);
      @(posedge sysclk); #1;
      rec(n);
    end
    tx_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge sysclk); #3;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({tx_ready, sig_rf, sig_enable, tx_busy, tx_done}
        !== 5'b10000) begin
      n_bad++;
      $display("FAIL reset_low got=%b want=10000",
               {tx_ready, sig_rf, sig_enable, tx_busy, tx_done});
    end
    @(posedge sysclk); #1;
    reset = 1'b1;
    @(posedge sysclk); #1;
    n_cmp++;
    if ({tx_ready, sig_rf, sig_enable, tx_busy, tx_done}
        !== 5'b10000) begin
      n_bad++;
      $display("FAIL reset_rel got=%b want=10000",
               {tx_ready, sig_rf, sig_enable, tx_busy, tx_done});
    end
  endtask

  task automatic test_ones();
    int ec, dc, first;
    capture(8'hFF, 1'b0, 132);
    ec = 0; dc = 0; first = -1;
    for (int n = 0; n <= 132; n++) begin
      if (en_t[n]) begin
        ec++;
        if (first < 0) first = n;
      end
      if (dn_t[n]) dc++;
    end
    n_cmp++;
    if (ec != 128 || first != 0 || en_t[127] !== 1'b1) begin
      n_bad++;
      $display("FAIL ones_enable got=%0d/%0d want=128/0",
               ec, first);
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (win_tog(i) != 8) begin
        n_bad++;
        $display("FAIL ones_win%0d got=%0d want=8",
                 i, win_tog(i));
      end
    end
    n_cmp++;
    if (dn_t[128] !== 1'b1 || dc != 1) begin
      n_bad++;
      $display("FAIL ones_done got=%b/%0d want=1/1",
               dn_t[128], dc);
    end
    n_cmp++;
    if (rd_t[129] !== 1'b1 || rd_t[128] !== 1'b0 ||
        bz_t[128] !== 1'b1 || bz_t[129] !== 1'b0) begin
      n_bad++;
      $display("FAIL ones_ready got=%b%b%b%b want=0110",
               rd_t[128], rd_t[129], bz_t[128], bz_t[129]);
    end
    n_cmp++;
    if (rf_errs(8'hFF) != 0) begin
      n_bad++;
      $display("FAIL ones_trace got=%0d want=0 errs",
               rf_errs(8'hFF));
    end
  endtask

  task automatic test_zeros();
    int tot, pos_bad;
    capture(8'h00, 1'b0, 132);
    tot = 0; pos_bad = 0;
    for (int n = 1; n <= 128; n++) begin
      if (rf_t[n] != rf_t[n-1]) begin
        tot++;
        if (((n - 1) % 16 + 1) % 8 != 0) pos_bad++;
      end
    end
    for (int i = 0; i < 8; i += 3) begin
      n_cmp++;
      if (win_tog(i) != 2) begin
        n_bad++;
        $display("FAIL zeros_win%0d got=%0d want=2",
                 i, win_tog(i));
      end
    end
    n_cmp++;
    if (tot != 16 || pos_bad != 0) begin
      n_bad++;
      $display("FAIL zeros_total got=%0d/%0d want=16/0",
               tot, pos_bad);
    end
    n_cmp++;
    if (rf_t[128] !== 1'b0 || dn_t[128] !== 1'b1) begin
      n_bad++;
      $display("FAIL zeros_done_rf got=%b%b want=01",
               rf_t[128], dn_t[128]);
    end
  endtask

  task automatic test_loopback();
    logic [7:0] r;
    capture(8'hA5, 1'b0, 132);
    r = demod();
    n_cmp++;
    if (r !== 8'hA5) begin
      n_bad++;
      $display("FAIL loop_a5 got=%h want=a5", r);
    end
  endtask

  task automatic test_random();
    logic [7:0] w, r;
    int e;
    for (int t = 0; t < 5; t++) begin
      w = 8'($urandom);
      capture(w, 1'b0, 131);
      e = rf_errs(w);
      r = demod();
      n_cmp++;
      if (e != 0 || r !== w || rf_t[130] !== rf_t[128]) begin
        n_bad++;
        $display("FAIL rand_%h got=errs%0d/%h want=0/%h",
                 w, e, r, w);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w;
    int e, b;
    w = 8'($urandom);
    capture(w, 1'b1, 131);
    e = rf_errs(w);
    n_cmp++;
    if (e != 0 || en_t[128] !== 1'b0) begin
      n_bad++;
      $display("FAIL hold_trace got=%0d want=0 errs", e);
    end
    n_cmp++;
    if (rd_t[129] !== 1'b1 || en_t[129] !== 1'b0 ||
        en_t[130] !== 1'b1 || rd_t[130] !== 1'b0) begin
      n_bad++;
      $display("FAIL hold_next got=%b%b%b%b want=1010",
               rd_t[129], en_t[129], en_t[130], rd_t[130]);
    end
    b = 0;
    while (tx_ready !== 1'b1 && b < 400) begin
      @(posedge sysclk); #1;
      b++;
    end
    n_cmp++;
    if (tx_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL hold_drain got=%b want=1", tx_ready);
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] w;
    int dc, e;
    capture(8'($urandom), 1'b0, 40);
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({tx_ready, sig_rf, sig_enable, tx_busy, tx_done}
        !== 5'b10000) begin
      n_bad++;
      $display("FAIL abort got=%b want=10000",
               {tx_ready, sig_rf, sig_enable, tx_busy, tx_done});
    end
    dc = 0;
    for (int n = 0; n < 3; n++) begin
      @(posedge sysclk); #1;
      if (tx_done) dc++;
    end
    reset = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(posedge sysclk); #1;
      if (tx_done) dc++;
    end
    n_cmp++;
    if (dc != 0) begin
      n_bad++;
      $display("FAIL abort_done got=%0d want=0", dc);
    end
    w = 8'($urandom);
    capture(w, 1'b0, 130);
    e = rf_errs(w);
    n_cmp++;
    if (e != 0 || dn_t[128] !== 1'b1 || demod() !== w) begin
      n_bad++;
      $display("FAIL abort_next got=errs%0d/%b want=0/1",
               e, dn_t[128]);
    end
  endtask

  initial begin
    reset    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    repeat (3) @(posedge sysclk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge sysclk);
    #1;
    test_reset();
    test_ones();
    test_zeros();
    test_loopback();
    test_random();
    test_back_to_back();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fsk_mod.md
Name: fsk_mod

Overview:
- Parallel-in FSK modulator. It is the transmit-side counterpart of the fsk_dem receiver.
- Accepts a DATA_W-bit word over a valid/ready handshake and serialises it MSB first.
- Each bit lasts SYM_LEN sysclk cycles. A '1' is sent as a fast square tone and a '0' as a slow square tone on sig_rf.
- sig_enable frames the burst so that it can drive the receiver's sig_enable directly in loopback.

Parameters:
- DATA_W, 8, bits per word.
- SYM_LEN, 16, sysclk cycles per bit. Must match the receiver window.
- HALF1, 2, half-period of the '1' tone in cycles, giving 8 toggles per bit at defaults.
- HALF0, 8, half-period of the '0' tone in cycles, giving 2 toggles per bit at defaults.

Ports:
- sysclk, input, 1, system clock. Rising edge active.
- reset, input, 1, asynchronous active-low reset.
- tx_data, input, DATA_W, word to transmit. Sampled on handshake.
- tx_valid, input, 1, tx_data is valid.
- tx_ready, output, 1, block can accept a word (IDLE only).
- sig_rf, output, 1, FSK modulated output.
- sig_enable, output, 1, high for exactly DATA_W*SYM_LEN cycles per word.
- tx_busy, output, 1, high in SEND and DONE.
- tx_done, output, 1, one-cycle pulse after the last bit.

Behaviour:
- Clock and reset:
  - One clock domain, sysclk.
  - Reset is asynchronous and active-low on port reset.
  - While reset is low: state=IDLE, sig_rf=0, sig_enable=0, tx_busy=0, tx_done=0, tx_ready=1, all counters and the shift register cleared.
- All outputs are registered.
- States:
  - IDLE: tx_ready=1.
  - SEND: sig_enable=1, tx_busy=1.
  - DONE: tx_done=1, tx_busy=1, sig_enable=0.
- Handshake:
  - A transfer occurs on the edge where tx_valid and tx_ready are both 1.
  - On that edge: shift register <= tx_data, bit_idx <= DATA_W-1, sym_cnt <= 0, tone_cnt <= 0, sig_rf <= 0, state <= SEND, tx_ready <= 0.
  - tx_valid outside IDLE is ignored. tx_data need not be held after the transfer.
- Latency: sig_enable rises one cycle after the handshake edge.
- Per SEND cycle:
  - Current bit b = shift register MSB. H = HALF1 if b=1, else HALF0.
  - If tone_cnt == H-1: toggle sig_rf and set tone_cnt <= 0. Otherwise tone_cnt <= tone_cnt+1.
  - sym_cnt increments.
- Bit boundary (sym_cnt == SYM_LEN-1):
  - sym_cnt <= 0, tone_cnt <= 0, shift left by 1, bit_idx decrements.
  - A toggle due in that same cycle still occurs.
  - sig_rf is not reset between bits (continuous level).
- Last bit boundary (bit_idx == 0): state <= DONE, sig_enable <= 0.
- DONE:
  - Lasts one cycle. sig_rf holds its value.
  - Next state is IDLE with tx_ready=1. sig_rf holds in IDLE until the next handshake clears it.
- Back-to-back words: minimum spacing is DATA_W*SYM_LEN+2 cycles from one handshake to the next.
- Counter widths: sym_cnt is clog2(SYM_LEN), tone_cnt is clog2(max(HALF0,HALF1)), bit_idx is clog2(DATA_W). All compare by equality, and wrap never exceeds the terminal value.
- Parameter constraints:
  - HALF1 < HALF0. Both must be >= 1 and <= SYM_LEN.
  - HALF1=1 gives a toggle every cycle.
- Reset mid-frame: immediate abort to reset values, with no tx_done pulse. The partial word is discarded.
- Receiver compatibility: at default parameters the toggle counts are 8 for a '1' and 2 for a '0'. These fall on either side of the receiver threshold of 6.

Decomposition:
- Shared package fsk_pkg:
  - State encoding constants ST_IDLE, ST_SEND, ST_DONE.
  - Default SYM_LEN=16 and the receiver threshold constant 6, shared with fsk_dem_judge.
  - Default HALF1 and HALF0 values.
- Sub-module fsk_tone_gen:
  - Holds tone_cnt and the sig_rf toggle.
  - Inputs: bit value, restart pulse (bit boundary) and clear (handshake).
  - Parameterised by HALF1 and HALF0.
- The top level holds the FSM, sym_cnt, bit_idx and the shift register.

Test Plan:
- Reset check: assert reset low mid-idle -> tx_ready=1, sig_rf=0, sig_enable=0, tx_busy=0, tx_done=0, checked while reset is low and on the first edge after release.
- Send 0xFF -> sig_enable high for exactly 128 cycles starting at handshake+1; 8 sig_rf toggles in every 16-cycle window; tx_done pulses at handshake+129; tx_ready=1 at handshake+130.
- Send 0x00 -> 2 toggles per window (at cycles 8 and 16 of each bit); 16 toggles total; sig_rf=0 at DONE.
- Send 0xA5 looped through fsk_dem (sig_rf and sig_enable connected) -> sampled sig_reb at bit ends reads 1,0,1,0,0,1,0,1.
- Hold tx_valid=1 with tx_data changing during SEND -> no second transfer; transmitted bits equal the word latched at the handshake; next transfer occurs at handshake+130.
- Pull reset low 40 cycles into a frame -> all outputs return to reset values immediately; no tx_done pulse; a new word sent after release is transmitted intact.
